gpgpu_cluster_top: RTL and testbench

Multi-SM successor to the single-core GPGPU top level. It instantiates `NUM_SM` `sm_core` instances behind the same host and code-memory pins, and adds three pieces of logic:
- a round-robin kernel dispatcher on the host request channel;
- a single-outstanding, round-robin code-memory arbiter;
- a registered, round-robin response collector that also reports which SM finished.

---
 rtl/gpgpu_cluster_pkg.sv | 40 ++++
 rtl/gpgpu_cluster_rr_arbiter.sv | 45 ++++
 rtl/sm_core.sv | 94 +++++++++
 rtl/gpgpu_cluster_top.sv | 187 ++++++++++++++++++
 tb/tb_gpgpu_cluster_top.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/gpgpu_cluster_pkg.sv
// gpgpu_cluster_pkg
//   Shared types and helpers for the multi-SM cluster.
//   - mem_arb_state_t : code-memory arbiter states
//   - sm_state_t      : sm_core kernel lifecycle states
//   - sm_id_width()   : width of an SM index for a given SM count
//   Also supplies default widths for the build-wide width macros when the
//   surrounding build does not define them.

`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 32
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

package gpgpu_cluster_pkg;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_arb_state_t;

    typedef enum logic [1:0] {
        SM_IDLE  = 2'd0,
        SM_FETCH = 2'd1,
        SM_RSP   = 2'd2
    } sm_state_t;

    // A single SM still needs a 1-bit index so ports never collapse to zero width.
    function automatic int sm_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpgpu_cluster_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin picker: selects the first asserted request
//   at or after the pointer, wrapping around.
//   Ports:
//     i_req [N]  request vector
//     i_ptr [W]  priority pointer (index of highest-priority requester)
//     o_gnt [N]  one-hot grant
//     o_idx [W]  encoded grant index (0 when nothing is requested)
//     o_any      at least one request is asserted

module rr_arbiter
    import gpgpu_cluster_pkg::*;
#(
    parameter int N = 4,
    parameter int W = sm_id_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_gnt,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W:0] w_cand;

    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            // Candidate index ptr+k folded back into 0..N-1.
            w_cand = {1'b0, i_ptr} + (W+1)'(k);
            if (w_cand >= (W+1)'(N)) begin
                w_cand = w_cand - (W+1)'(N);
            end
            if (!o_any && i_req[w_cand[W-1:0]]) begin
                o_any                 = 1'b1;
                o_idx                 = w_cand[W-1:0];
                o_gnt[w_cand[W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm_core.sv
// sm_core
//   Streaming multiprocessor kernel engine as seen by the cluster: accepts one
//   kernel, fetches the code word at the kernel start address, then reports
//   the low WID_W bits of that word as the finished warp id.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     tpc_req_ready_o/valid_i       kernel request handshake
//     tpc_req_start_addr_i          kernel start address
//     code_mem_available_i          cluster memory path can take a read
//     code_read_valid_o/addr_o      code read request (held until ready)
//     code_read_ready_i/data_i      code read return
//     tpc_rsp_valid_o/wid_o         completion report
//     tpc_rsp_ready_i               completion accepted

module sm_core
    import gpgpu_cluster_pkg::*;
#(
    parameter int CODE_MEM_ADDR_W = 32,
    parameter int CODE_MEM_DATA_W = 32,
    parameter int CODE_ADDR_W     = 32,
    parameter int WID_W           = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       tpc_req_ready_o,
    input  logic                       tpc_req_valid_i,
    input  logic [CODE_ADDR_W-1:0]     tpc_req_start_addr_i,
    input  logic                       code_mem_available_i,
    output logic                       code_read_valid_o,
    output logic [CODE_MEM_ADDR_W-1:0] code_read_addr_o,
    input  logic                       code_read_ready_i,
    input  logic [CODE_MEM_DATA_W-1:0] code_read_data_i,
    output logic                       tpc_rsp_valid_o,
    output logic [WID_W-1:0]           tpc_rsp_wid_o,
    input  logic                       tpc_rsp_ready_i
);

    sm_state_t                  r_state;
    logic                       r_req_ready;
    logic                       r_rd_vld_p1;
    logic                       r_rsp_vld_p1;
    logic [CODE_MEM_ADDR_W-1:0] r_addr;
    logic [WID_W-1:0]           r_wid;

    // The request is held until the cluster returns data, so availability
    // carries no extra information for this core.
    logic w_unused;
    assign w_unused = &{1'b0, code_mem_available_i, code_read_data_i};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= SM_IDLE;
            r_req_ready  <= 1'b1;
            r_rd_vld_p1  <= 1'b0;
            r_rsp_vld_p1 <= 1'b0;
            r_addr       <= '0;
            r_wid        <= '0;
        end else begin
            case (r_state)
                SM_IDLE: begin
                    if (tpc_req_valid_i) begin
                        r_addr      <= CODE_MEM_ADDR_W'(tpc_req_start_addr_i);
                        r_req_ready <= 1'b0;
                        r_rd_vld_p1 <= 1'b1;
                        r_state     <= SM_FETCH;
                    end
                end
                SM_FETCH: begin
                    if (code_read_ready_i) begin
                        r_wid        <= code_read_data_i[WID_W-1:0];
                        r_rd_vld_p1  <= 1'b0;
                        r_rsp_vld_p1 <= 1'b1;
                        r_state      <= SM_RSP;
                    end
                end
                SM_RSP: begin
                    if (tpc_rsp_ready_i) begin
                        r_rsp_vld_p1 <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= SM_IDLE;
                    end
                end
                default: r_state <= SM_IDLE;
            endcase
        end
    end

    assign tpc_req_ready_o   = r_req_ready;
    assign code_read_valid_o = r_rd_vld_p1;
    assign code_read_addr_o  = r_addr;
    assign tpc_rsp_valid_o   = r_rsp_vld_p1;
    assign tpc_rsp_wid_o     = r_wid;

endmodule

// File: rtl/gpgpu_cluster_top.sv
// gpgpu_cluster_top
//   NUM_SM sm_core instances sharing one host channel and one code memory.
//   - Kernel dispatch: combinational round-robin over ready SMs.
//   - Code memory: one outstanding read, round-robin over requesting SMs.
//   - Responses: one registered slot, round-robin over finished SMs,
//     tagged with the index of the SM that finished.
//   Ports:
//     clk, rst                              clock, synchronous active-high reset
//     code_mem_available_i                  external memory can take a read
//     code_read_valid_o/addr_o              registered read request
//     code_read_ready_i/data_i              read return
//     host_req_ready_o/valid_i/start_addr_i kernel request channel
//     host_rsp_ready_i/valid_o/wid_o/sm_id_o response channel (registered)

`ifndef CODE_MEM_ADDR_WIDTH
`define CODE_MEM_ADDR_WIDTH 32
`endif
`ifndef CODE_MEM_DATA_WIDTH
`define CODE_MEM_DATA_WIDTH 32
`endif
`ifndef CODE_ADDR_WIDTH
`define CODE_ADDR_WIDTH 32
`endif
`ifndef DEPTH_WARP
`define DEPTH_WARP 3
`endif

module gpgpu_cluster_top
    import gpgpu_cluster_pkg::*;
#(
    parameter int NUM_SM          = 4,
    parameter int SM_ID_W         = sm_id_width(NUM_SM),
    parameter int CODE_MEM_ADDR_W = `CODE_MEM_ADDR_WIDTH,
    parameter int CODE_MEM_DATA_W = `CODE_MEM_DATA_WIDTH,
    parameter int CODE_ADDR_W     = `CODE_ADDR_WIDTH,
    parameter int WID_W           = `DEPTH_WARP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       code_mem_available_i,
    output logic                       code_read_valid_o,
    output logic [CODE_MEM_ADDR_W-1:0] code_read_addr_o,
    input  logic                       code_read_ready_i,
    input  logic [CODE_MEM_DATA_W-1:0] code_read_data_i,
    output logic                       host_req_ready_o,
    input  logic                       host_req_valid_i,
    input  logic [CODE_ADDR_W-1:0]     host_req_start_addr_i,
    input  logic                       host_rsp_ready_i,
    output logic                       host_rsp_valid_o,
    output logic [WID_W-1:0]           host_rsp_wid_o,
    output logic [SM_ID_W-1:0]         host_rsp_sm_id_o
);

    function automatic logic [SM_ID_W-1:0] inc_wrap(input logic [SM_ID_W-1:0] v);
        return (v == SM_ID_W'(NUM_SM-1)) ? '0 : v + SM_ID_W'(1);
    endfunction

    logic [NUM_SM-1:0]          w_sm_req_ready, w_sm_req_valid, w_sm_mem_avail;
    logic [NUM_SM-1:0]          w_sm_rd_valid, w_sm_rd_ready, w_sm_rsp_valid, w_sm_rsp_ready;
    logic [CODE_MEM_ADDR_W-1:0] w_sm_rd_addr [NUM_SM];
    logic [CODE_MEM_DATA_W-1:0] w_sm_rd_data [NUM_SM];
    logic [WID_W-1:0]           w_sm_rsp_wid [NUM_SM];

    logic [NUM_SM-1:0]  w_req_gnt, w_mem_gnt_unused, w_rsp_gnt;
    logic [SM_ID_W-1:0] w_req_idx, w_mem_idx, w_rsp_idx;
    logic               w_req_any, w_mem_any, w_rsp_any;
    logic               w_req_fire, w_rsp_load, w_rst_n;

    logic [SM_ID_W-1:0]         r_req_ptr, r_mem_ptr, r_rsp_ptr, r_mem_owner;
    mem_arb_state_t             r_mem_state;
    logic                       r_rd_vld_p1;
    logic [CODE_MEM_ADDR_W-1:0] r_rd_addr_p1;
    logic                       r_rsp_vld_p1;
    logic [WID_W-1:0]           r_rsp_wid_p1;
    logic [SM_ID_W-1:0]         r_rsp_sm_id_p1;

    assign w_rst_n = ~rst;

    rr_arbiter #(.N(NUM_SM), .W(SM_ID_W)) u_req_arb (
        .i_req(w_sm_req_ready), .i_ptr(r_req_ptr),
        .o_gnt(w_req_gnt), .o_idx(w_req_idx), .o_any(w_req_any)
    );

    rr_arbiter #(.N(NUM_SM), .W(SM_ID_W)) u_mem_arb (
        .i_req(w_sm_rd_valid), .i_ptr(r_mem_ptr),
        .o_gnt(w_mem_gnt_unused), .o_idx(w_mem_idx), .o_any(w_mem_any)
    );

    rr_arbiter #(.N(NUM_SM), .W(SM_ID_W)) u_rsp_arb (
        .i_req(w_sm_rsp_valid), .i_ptr(r_rsp_ptr),
        .o_gnt(w_rsp_gnt), .o_idx(w_rsp_idx), .o_any(w_rsp_any)
    );

    assign host_req_ready_o = w_req_any & ~rst;
    assign w_req_fire       = host_req_valid_i & host_req_ready_o;
    // The slot can take a new entry when empty or when the host drains it now.
    assign w_rsp_load       = ~r_rsp_vld_p1 | host_rsp_ready_i;

    for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
        logic w_owner_rd;
        // Read returns are steered only to the SM that owns the outstanding read.
        assign w_owner_rd = (r_mem_state == MEM_BUSY) && (r_mem_owner == SM_ID_W'(g))
                            && code_read_ready_i;
        assign w_sm_req_valid[g] = host_req_valid_i & w_req_gnt[g];
        assign w_sm_mem_avail[g] = code_mem_available_i & (r_mem_state == MEM_IDLE);
        assign w_sm_rd_ready[g]  = w_owner_rd;
        assign w_sm_rd_data[g]   = w_owner_rd ? code_read_data_i : '0;
        assign w_sm_rsp_ready[g] = w_rsp_load & w_rsp_gnt[g] & ~rst;

        sm_core #(
            .CODE_MEM_ADDR_W(CODE_MEM_ADDR_W), .CODE_MEM_DATA_W(CODE_MEM_DATA_W),
            .CODE_ADDR_W(CODE_ADDR_W), .WID_W(WID_W)
        ) u_sm (
            .clk(clk), .rst_n(w_rst_n),
            .tpc_req_ready_o(w_sm_req_ready[g]), .tpc_req_valid_i(w_sm_req_valid[g]),
            .tpc_req_start_addr_i(host_req_start_addr_i),
            .code_mem_available_i(w_sm_mem_avail[g]),
            .code_read_valid_o(w_sm_rd_valid[g]), .code_read_addr_o(w_sm_rd_addr[g]),
            .code_read_ready_i(w_sm_rd_ready[g]), .code_read_data_i(w_sm_rd_data[g]),
            .tpc_rsp_valid_o(w_sm_rsp_valid[g]), .tpc_rsp_wid_o(w_sm_rsp_wid[g]),
            .tpc_rsp_ready_i(w_sm_rsp_ready[g])
        );
    end

    // Dispatch pointer: next search starts just past the SM that took the kernel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ptr <= '0;
        end else if (w_req_fire) begin
            r_req_ptr <= inc_wrap(w_req_idx);
        end
    end

    // Code-memory arbiter FSM: request register stage (_p1) toward memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_state  <= MEM_IDLE;
            r_mem_ptr    <= '0;
            r_mem_owner  <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_addr_p1 <= '0;
        end else begin
            case (r_mem_state)
                MEM_IDLE: begin
                    if (w_mem_any && code_mem_available_i) begin
                        r_mem_owner  <= w_mem_idx;
                        r_rd_addr_p1 <= w_sm_rd_addr[w_mem_idx];
                        r_rd_vld_p1  <= 1'b1;
                        r_mem_state  <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    if (code_read_ready_i) begin
                        r_rd_vld_p1 <= 1'b0;
                        r_mem_ptr   <= inc_wrap(r_mem_owner);
                        r_mem_state <= MEM_IDLE;
                    end
                end
                default: r_mem_state <= MEM_IDLE;
            endcase
        end
    end

    // Response collector: single output register stage (_p1) toward the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_ptr      <= '0;
            r_rsp_vld_p1   <= 1'b0;
            r_rsp_wid_p1   <= '0;
            r_rsp_sm_id_p1 <= '0;
        end else if (w_rsp_load) begin
            r_rsp_vld_p1 <= w_rsp_any;
            if (w_rsp_any) begin
                r_rsp_wid_p1   <= w_sm_rsp_wid[w_rsp_idx];
                r_rsp_sm_id_p1 <= w_rsp_idx;
                r_rsp_ptr      <= inc_wrap(w_rsp_idx);
            end
        end
    end

    assign code_read_valid_o = r_rd_vld_p1;
    assign code_read_addr_o  = r_rd_addr_p1;
    assign host_rsp_valid_o  = r_rsp_vld_p1;
    assign host_rsp_wid_o    = r_rsp_wid_p1;
    assign host_rsp_sm_id_o  = r_rsp_sm_id_p1;

endmodule

// File: tb/tb_gpgpu_cluster_top.sv
// tb_gpgpu_cluster_top
//   Directed scenarios followed by random traffic. A kernel-level model tracks
//   each SM as free / fetching / reporting, with three round-robin pointers,
//   and predicts every host-visible output cycle by cycle.

module tb_gpgpu_cluster_top;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        code_mem_available_i;
    logic        code_read_valid_o;
    logic [31:0] code_read_addr_o;
    logic        code_read_ready_i;
    logic [31:0] code_read_data_i;
    logic        host_req_ready_o;
    logic        host_req_valid_i;
    logic [31:0] host_req_start_addr_i;
    logic        host_rsp_ready_i;
    logic        host_rsp_valid_o;
    logic [2:0]  host_rsp_wid_o;
    logic [1:0]  host_rsp_sm_id_o;

    gpgpu_cluster_top #(
        .NUM_SM(N), .SM_ID_W(2), .CODE_MEM_ADDR_W(32), .CODE_MEM_DATA_W(32),
        .CODE_ADDR_W(32), .WID_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .code_mem_available_i(code_mem_available_i),
        .code_read_valid_o(code_read_valid_o), .code_read_addr_o(code_read_addr_o),
        .code_read_ready_i(code_read_ready_i), .code_read_data_i(code_read_data_i),
        .host_req_ready_o(host_req_ready_o), .host_req_valid_i(host_req_valid_i),
        .host_req_start_addr_i(host_req_start_addr_i),
        .host_rsp_ready_i(host_rsp_ready_i), .host_rsp_valid_o(host_rsp_valid_o),
        .host_rsp_wid_o(host_rsp_wid_o), .host_rsp_sm_id_o(host_rsp_sm_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: 0 = free, 1 = waiting for code, 2 = holding a result.
    int          m_st   [N];
    logic [31:0] m_addr [N];
    int          m_wid  [N];
    int          m_req_ptr, m_mem_ptr, m_rsp_ptr;
    bit          m_busy;
    int          m_owner;
    logic [31:0] m_out_addr;
    bit          m_rv;
    int          m_rwid, m_rid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int ptr, input int want);
        for (int k = 0; k < N; k++) begin
            int j = (ptr + k) % N;
            if (m_st[j] == want) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_addr[i] = 0; m_wid[i] = 0;
        end
        m_req_ptr = 0; m_mem_ptr = 0; m_rsp_ptr = 0;
        m_busy = 0; m_owner = 0; m_out_addr = 0;
        m_rv = 0; m_rwid = 0; m_rid = 0;
    endtask

    // One clock cycle: drive inputs, check the combinational ready, advance
    // the model across the edge, then check the registered outputs.
    task automatic step(input bit hv, input logic [31:0] ha, input bit av, input bit rd,
                        input logic [31:0] dat, input bit hr, input bit rs);
        int g, mg, rw;
        bit load;
        host_req_valid_i      = hv;
        host_req_start_addr_i = ha;
        code_mem_available_i  = av;
        code_read_ready_i     = rd;
        code_read_data_i      = dat;
        host_rsp_ready_i      = hr;
        rst                   = rs;
        #1;
        g = pick(m_req_ptr, 0);
        chk("host_req_ready", {31'd0, host_req_ready_o}, {31'd0, (!rs && g >= 0)});
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            mg   = (!m_busy && av) ? pick(m_mem_ptr, 1) : -1;
            load = !m_rv || hr;
            rw   = load ? pick(m_rsp_ptr, 2) : -1;
            if (hv && g >= 0) begin
                m_st[g] = 1; m_addr[g] = ha; m_req_ptr = (g + 1) % N;
            end
            if (m_busy) begin
                if (rd) begin
                    m_st[m_owner] = 2; m_wid[m_owner] = int'(dat & 32'h7);
                    m_busy = 0; m_mem_ptr = (m_owner + 1) % N;
                end
            end else if (mg >= 0) begin
                m_busy = 1; m_owner = mg; m_out_addr = m_addr[mg];
            end
            if (load) begin
                m_rv = (rw >= 0);
                if (rw >= 0) begin
                    m_rwid = m_wid[rw]; m_rid = rw; m_st[rw] = 0; m_rsp_ptr = (rw + 1) % N;
                end
            end
        end
        #1;
        chk("code_read_valid", {31'd0, code_read_valid_o}, {31'd0, m_busy});
        if (m_busy) chk("code_read_addr", code_read_addr_o, m_out_addr);
        chk("host_rsp_valid", {31'd0, host_rsp_valid_o}, {31'd0, m_rv});
        if (m_rv) begin
            chk("host_rsp_wid", {29'd0, host_rsp_wid_o}, m_rwid);
            chk("host_rsp_sm_id", {30'd0, host_rsp_sm_id_o}, m_rid);
        end
        if (rs) begin
            chk("rst_code_read_addr", code_read_addr_o, 32'd0);
            chk("rst_host_rsp_wid", {29'd0, host_rsp_wid_o}, 32'd0);
            chk("rst_host_rsp_sm_id", {30'd0, host_rsp_sm_id_o}, 32'd0);
        end
    endtask

    // Memory that answers each read 3 cycles after its valid first appears.
    // The kernel at 0x103 returns warp id 5; others return random words.
    task automatic serve(input int cycles, input bit hr);
        int age = 0;
        for (int c = 0; c < cycles; c++) begin
            bit v, rd;
            logic [31:0] dat;
            v   = code_read_valid_o;
            rd  = v && (age == 3);
            dat = (code_read_addr_o == 32'h103) ? 32'h5 : $urandom;
            step(1'b0, 32'h0, 1'b1, rd, dat, hr, 1'b0);
            age = (v && !rd) ? age + 1 : 0;
        end
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        host_req_valid_i = 0; host_req_start_addr_i = 0; code_mem_available_i = 0;
        code_read_ready_i = 0; code_read_data_i = 0; host_rsp_ready_i = 0;

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Four back-to-back kernels land on SM0..SM3; a fifth finds no free SM.
        for (int k = 0; k < 4; k++) step(1, 32'h100 + k, 0, 0, 0, 1, 0);
        step(1, 32'h200, 0, 0, 0, 1, 0);

        // Reads serialised in SM order; host stalls so the first result is held.
        serve(24, 1'b0);
        // Release the host: the remaining results stream out back to back.
        serve(12, 1'b1);

        // Memory unavailable with pending reads: nothing may be issued.
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 32'h300, 0, 0, 0, 1, 0);
        step(1, 32'h301, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
        serve(16, 1'b1);

        // Reset during an outstanding read, then a stale ready afterwards.
        step(1, 32'h400, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 1, 1, 32'h7, 1, 0);
        step(0, 0, 1, 0, 0, 1, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) < 2), $urandom,
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
